// File: rtl/pat_det_ctrl.sv
// Programmable serial pattern detector: config handshake, arm/run/done sequencing, match counting.
// Optional bit-count timeout in RUN is enabled by defining PAT_DET_TIMEOUT_EN.
module pat_det_ctrl #(
   parameter int MAX_LEN = 8,
   parameter int CNT_W   = 8,
   parameter int TO_BITS = 64
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               cfg_valid,
   output logic               cfg_ready,
   input  logic [MAX_LEN-1:0] cfg_pattern,
   input  logic [4:0]         cfg_len,
   input  logic               cfg_overlap,
   input  logic [CNT_W-1:0]   cfg_target,
   output logic               cfg_err,
   input  logic               start,
   input  logic               abort,
   input  logic               din,
   input  logic               din_valid,
   output logic               dout,
   output logic [CNT_W-1:0]   match_cnt,
   output logic               busy,
   output logic               done,
   output logic               timeout
);

   typedef enum logic [1:0] {S_IDLE, S_ARMED, S_RUN, S_DONE} state_t;

   state_t             state_q, state_d;
   logic [MAX_LEN-1:0] pat_q, pat_d, hist_q, hist_d, hist_sh, mask;
   logic [4:0]         len_q, len_d, fill_q, fill_d, fill_sh;
   logic               ovl_q, ovl_d;
   logic [CNT_W-1:0]   tgt_q, tgt_d, cnt_q, cnt_d, cnt_inc;
   logic               dout_q, dout_d, err_q, err_d;
   logic               hit, len_ok;

`ifdef PAT_DET_TIMEOUT_EN
   localparam int TO_W = $clog2(TO_BITS + 1);
   logic [TO_W-1:0] to_cnt_q, to_cnt_d, to_inc;
   logic            to_flag_q, to_flag_d;
`endif

   // Newest bit lands in hist[0], so hist[len-1] holds the first bit of the window.
   always_comb begin
      for (int i = 0; i < MAX_LEN; i++) mask[i] = (5'(i) < len_q);
      hist_sh = {hist_q[MAX_LEN-2:0], din};
      fill_sh = (fill_q >= len_q) ? len_q : fill_q + 5'd1;
      hit     = (fill_sh == len_q) && (((hist_sh ^ pat_q) & mask) == '0);
      cnt_inc = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
      len_ok  = (cfg_len != 5'd0) && (cfg_len <= 5'(MAX_LEN));
   end

   always_comb begin
      state_d = state_q;
      pat_d   = pat_q;
      len_d   = len_q;
      ovl_d   = ovl_q;
      tgt_d   = tgt_q;
      hist_d  = hist_q;
      fill_d  = fill_q;
      cnt_d   = cnt_q;
      dout_d  = 1'b0;
      err_d   = 1'b0;
`ifdef PAT_DET_TIMEOUT_EN
      to_cnt_d  = to_cnt_q;
      to_flag_d = to_flag_q;
      to_inc    = to_cnt_q + 1'b1;
`endif
      if (abort) begin
         state_d = S_IDLE;
         cnt_d   = '0;
`ifdef PAT_DET_TIMEOUT_EN
         to_flag_d = 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (cfg_valid) begin
                  if (len_ok) begin
                     pat_d   = cfg_pattern;
                     len_d   = cfg_len;
                     ovl_d   = cfg_overlap;
                     tgt_d   = cfg_target;
                     state_d = S_ARMED;
                  end else begin
                     err_d = 1'b1;
                  end
               end
            end
            S_ARMED, S_DONE: begin
               if (start) begin
                  state_d = S_RUN;
                  hist_d  = '0;
                  fill_d  = '0;
                  cnt_d   = '0;
`ifdef PAT_DET_TIMEOUT_EN
                  to_cnt_d  = '0;
                  to_flag_d = 1'b0;
`endif
               end
            end
            S_RUN: begin
               if (din_valid) begin
                  hist_d = hist_sh;
                  fill_d = fill_sh;
                  if (hit) begin
                     dout_d = 1'b1;
                     cnt_d  = cnt_inc;
                     if (!ovl_q) fill_d = '0;
                     if (tgt_q != '0 && cnt_inc == tgt_q) state_d = S_DONE;
`ifdef PAT_DET_TIMEOUT_EN
                     to_cnt_d = '0;
                  end else begin
                     to_cnt_d = to_inc;
                     if (to_inc == TO_W'(TO_BITS)) begin
                        state_d   = S_DONE;
                        to_flag_d = 1'b1;
                     end
`endif
                  end
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         pat_q   <= '0;
         len_q   <= '0;
         ovl_q   <= 1'b0;
         tgt_q   <= '0;
         hist_q  <= '0;
         fill_q  <= '0;
         cnt_q   <= '0;
         dout_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pat_q   <= pat_d;
         len_q   <= len_d;
         ovl_q   <= ovl_d;
         tgt_q   <= tgt_d;
         hist_q  <= hist_d;
         fill_q  <= fill_d;
         cnt_q   <= cnt_d;
         dout_q  <= dout_d;
         err_q   <= err_d;
      end
   end

`ifdef PAT_DET_TIMEOUT_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         to_cnt_q  <= '0;
         to_flag_q <= 1'b0;
      end else begin
         to_cnt_q  <= to_cnt_d;
         to_flag_q <= to_flag_d;
      end
   end
   assign timeout = to_flag_q;
`else
   assign timeout = 1'b0;
`endif

   assign cfg_ready = (state_q == S_IDLE);
   assign busy      = (state_q == S_RUN);
   assign done      = (state_q == S_DONE);
   assign dout      = dout_q;
   assign match_cnt = cnt_q;
   assign cfg_err   = err_q;

endmodule

// File: tb/tb_pat_det_ctrl.sv
// Directed bench for pat_det_ctrl: table-driven stream checks plus hand-written corner sequences.
module tb_pat_det_ctrl;
   localparam int ML = 8;
   localparam int CW = 8;

   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          cfg_valid = 1'b0, cfg_ready;
   logic [ML-1:0] cfg_pattern = '0;
   logic [4:0]    cfg_len = '0;
   logic          cfg_overlap = 1'b0;
   logic [CW-1:0] cfg_target = '0;
   logic          cfg_err, start = 1'b0, abort = 1'b0, din = 1'b0, din_valid = 1'b0;
   logic          dout, busy, done, timeout;
   logic [CW-1:0] match_cnt;

   int total = 0;
   int bad   = 0;

   typedef struct {
      logic din;
      logic d_ov1;
      logic d_ov0;
   } vec_t;
   vec_t tbl[16];

   pat_det_ctrl #(.MAX_LEN(ML), .CNT_W(CW), .TO_BITS(64)) dut (
      .clk(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
      .cfg_pattern(cfg_pattern), .cfg_len(cfg_len), .cfg_overlap(cfg_overlap),
      .cfg_target(cfg_target), .cfg_err(cfg_err), .start(start), .abort(abort),
      .din(din), .din_valid(din_valid), .dout(dout), .match_cnt(match_cnt),
      .busy(busy), .done(done), .timeout(timeout)
   );

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic cfg(input logic [ML-1:0] p, input logic [4:0] l, input logic o, input logic [CW-1:0] t);
      cfg_pattern = p; cfg_len = l; cfg_overlap = o; cfg_target = t;
      cfg_valid = 1'b1;
      step();
      cfg_valid = 1'b0;
   endtask

   task automatic go();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   task automatic kill();
      abort = 1'b1;
      step();
      abort = 1'b0;
   endtask

   task automatic bitin(input logic b);
      din = b; din_valid = 1'b1;
      step();
      din_valid = 1'b0; din = 1'b0;
   endtask

   task automatic chk_reset_vals(input string tag);
      chk({tag, "_ready"}, cfg_ready, 1);
      chk({tag, "_busy"}, busy, 0);
      chk({tag, "_done"}, done, 0);
      chk({tag, "_dout"}, dout, 0);
      chk({tag, "_cnt"}, match_cnt, 0);
      chk({tag, "_err"}, cfg_err, 0);
      chk({tag, "_tmo"}, timeout, 0);
   endtask

   initial begin
      logic [15:0] s;
      int          ecnt;
      s = 16'b0001_0010_1101_1010;
      for (int i = 0; i < 16; i++) begin
         tbl[i].din   = s[15-i];
         tbl[i].d_ov1 = (i == 11 || i == 14);
         tbl[i].d_ov0 = (i == 11);
      end

      step(); step();
      rst = 1'b0;
      chk_reset_vals("rst");

      // overlapping, unlimited target
      cfg(8'b0000_1101, 5'd4, 1'b1, '0);
      chk("armed_ready", cfg_ready, 0);
      go();
      chk("run_busy", busy, 1);
      ecnt = 0;
      for (int i = 0; i < 16; i++) begin
         bitin(tbl[i].din);
         if (tbl[i].d_ov1) ecnt++;
         chk($sformatf("ov1_dout%0d", i), dout, tbl[i].d_ov1);
         chk($sformatf("ov1_cnt%0d", i), match_cnt, ecnt);
         chk($sformatf("ov1_busy%0d", i), busy, 1);
      end
      chk("ov1_total", match_cnt, 2);
      kill();
      chk("abort_ready", cfg_ready, 1);
      chk("abort_cnt", match_cnt, 0);

      // non-overlapping
      cfg(8'b0000_1101, 5'd4, 1'b0, '0);
      go();
      ecnt = 0;
      for (int i = 0; i < 16; i++) begin
         bitin(tbl[i].din);
         if (tbl[i].d_ov0) ecnt++;
         chk($sformatf("ov0_dout%0d", i), dout, tbl[i].d_ov0);
         chk($sformatf("ov0_cnt%0d", i), match_cnt, ecnt);
      end
      chk("ov0_total", match_cnt, 1);
      kill();

      // target = 1 stops after first hit
      cfg(8'b0000_1101, 5'd4, 1'b1, 8'd1);
      go();
      for (int i = 0; i < 16; i++) begin
         bitin(tbl[i].din);
         chk($sformatf("t1_dout%0d", i), dout, (i == 11));
         chk($sformatf("t1_cnt%0d", i), match_cnt, (i >= 11) ? 1 : 0);
         chk($sformatf("t1_done%0d", i), done, (i >= 11));
         chk($sformatf("t1_busy%0d", i), busy, (i < 11));
      end
      go();
      chk("rerun_busy", busy, 1);
      chk("rerun_done", done, 0);
      chk("rerun_cnt", match_cnt, 0);
      bitin(1); bitin(1); bitin(0); bitin(1);
      chk("rerun_dout", dout, 1);
      chk("rerun_done2", done, 1);
      kill();

      // illegal lengths
      cfg(8'hFF, 5'd0, 1'b0, '0);
      chk("len0_err", cfg_err, 1);
      chk("len0_ready", cfg_ready, 1);
      step();
      chk("len0_err_drop", cfg_err, 0);
      cfg(8'hFF, 5'(ML + 1), 1'b0, '0);
      chk("len9_err", cfg_err, 1);
      chk("len9_ready", cfg_ready, 1);
      go();
      chk("idle_start_ign", busy, 0);
      chk("idle_start_rdy", cfg_ready, 1);
      chk("len9_err_drop", cfg_err, 0);

      // din_valid gaps inside the pattern
      cfg(8'b0000_1101, 5'd4, 1'b1, '0);
      go();
      bitin(1); step();
      bitin(1); step(); step();
      bitin(0);
      chk("gap_nodout", dout, 0);
      step();
      chk("gap_idle_dout", dout, 0);
      bitin(1);
      chk("gap_dout", dout, 1);
      chk("gap_cnt", match_cnt, 1);
      kill();

      // abort coincident with a matching final bit
      cfg(8'b0000_1101, 5'd4, 1'b1, '0);
      go();
      bitin(1); bitin(1); bitin(0); bitin(1);
      chk("pre_abort_cnt", match_cnt, 1);
      bitin(1); bitin(0);
      din = 1'b1; din_valid = 1'b1; abort = 1'b1;
      step();
      din = 1'b0; din_valid = 1'b0; abort = 1'b0;
      chk("abm_dout", dout, 0);
      chk("abm_ready", cfg_ready, 1);
      chk("abm_busy", busy, 0);
      chk("abm_cnt", match_cnt, 0);

      // reset in the middle of a run
      cfg(8'b0000_1101, 5'd4, 1'b1, '0);
      go();
      bitin(1); bitin(1); bitin(0); bitin(1);
      chk("prerst_dout", dout, 1);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk_reset_vals("midrst");

      // long run of zeros: timeout only when the feature is built in
      cfg(8'b0000_1101, 5'd4, 1'b1, '0);
      go();
      for (int i = 0; i < 63; i++) bitin(0);
      chk("to63_tmo", timeout, 0);
      chk("to63_busy", busy, 1);
      bitin(0);
`ifdef PAT_DET_TIMEOUT_EN
      chk("to64_tmo", timeout, 1);
      chk("to64_done", done, 1);
      chk("to64_busy", busy, 0);
      go();
      chk("to_restart_tmo", timeout, 0);
`else
      chk("to64_tmo", timeout, 0);
      chk("to64_done", done, 0);
      chk("to64_busy", busy, 1);
`endif
      kill();
      chk("final_ready", cfg_ready, 1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/pat_det_ctrl.md
Name: pat_det_ctrl

Overview:
- Controller and datapath for a programmable serial pattern detector, the generalised successor of the fixed 1101 detector.
- Accepts a pattern/length/mode configuration through a valid/ready handshake, then arms and runs detection on a serial bit stream.
- Counts matches and stops automatically after a programmed number of hits.
- Sits between a host config/sequencer and a serial input front-end.

Parameters:
MAX_LEN, 8, maximum pattern length in bits (2..16)
CNT_W, 8, width of match counter and target
TO_BITS, 64, timeout threshold in valid bits (used only with optional feature)

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
cfg_valid  in  1  config offer
cfg_ready  out  1  config accept (high only in IDLE)
cfg_pattern  in  MAX_LEN  pattern; bit [cfg_len-1] is the first bit expected on the wire
cfg_len  in  5  pattern length, legal range 1..MAX_LEN
cfg_overlap  in  1  1 = overlapping matches allowed
cfg_target  in  CNT_W  matches before DONE; 0 = run until abort
cfg_err  out  1  one-cycle pulse on illegal cfg_len
start  in  1  arm/launch run
abort  in  1  return to IDLE
din  in  1  serial data
din_valid  in  1  din qualifier
dout  out  1  one-cycle match pulse
match_cnt  out  CNT_W  matches this run
busy  out  1  high in RUN
done  out  1  high in DONE
timeout  out  1  see Optional Feature

Behaviour:
- Reset values: IDLE; all outputs 0 except cfg_ready=1; config registers, history, fill and counters cleared.
- States: IDLE, ARMED, RUN, DONE. The state register is binary encoded.
- IDLE:
  - cfg_valid & cfg_ready with cfg_len in 1..MAX_LEN: latch pattern, len, overlap and target; go to ARMED.
  - Illegal len: cfg_err=1 for one cycle; config is not latched; stay in IDLE.
  - start is ignored.
- ARMED: start -> RUN. On the same edge, clear history, fill and match_cnt.
- RUN, on each cycle with din_valid=1:
  - hist <= {hist[MAX_LEN-2:0], din}.
  - fill increments, saturating at len.
  - Match when the post-shift fill equals len and hist[len-1:0] equals pattern[len-1:0].
  - din_valid=0 cycles are ignored: no shift, no fill change.
- Match timing: dout is registered and high for exactly the one cycle after the edge that sampled the final bit of the match. match_cnt updates on that same edge and saturates at all-ones.
- Overlap: if overlap=1, history is retained after a match. If overlap=0, fill is reset to 0 on the match edge, so the next match needs len fresh bits.
- Target reached: when target!=0 and match_cnt reaches target, the state moves to DONE on the same edge. dout still pulses and busy falls.
- DONE: done=1 (level). start -> RUN with a fresh clear of history, fill and count; the same config is reused. cfg_valid is ignored.
- abort: in any state, go to IDLE on the next edge. Config registers are kept; match_cnt and dout are cleared. abort has priority over start, match and cfg handshake in the same cycle.
- rst has priority over everything.

Optional Feature:
- Macro PAT_DET_TIMEOUT_EN.
- Defined:
  - In RUN, a counter counts din_valid bits since the last match or run start.
  - When it reaches TO_BITS with no match, go to DONE with timeout=1 and done=1.
  - timeout clears on the next start or abort.
  - A match on the same bit as expiry wins: dout pulses and timeout stays 0.
- Undefined: no counter; timeout tied to 0.

Test Plan:
- Reset, then cfg pattern=8'b0000_1101, len=4, overlap=1, target=0, start; stream 0,0,0,1,0,0,1,0,1,1,0,1,1,0,1,0 (one bit per valid) -> dout pulses after bits 11 and 14; match_cnt=2; busy stays 1.
- Same stream with overlap=0 -> single dout after bit 11; match_cnt=1.
- overlap=1, target=1 -> DONE after bit 11; done=1; busy=0; later bits ignored. Then start -> rerun with match_cnt cleared to 0.
- cfg_len=0 and cfg_len=MAX_LEN+1 -> cfg_err pulses, state stays IDLE, cfg_ready stays 1. Also insert din_valid=0 gaps mid-pattern -> match still detected.
- abort asserted in the same cycle as a matching final bit -> no dout, IDLE next cycle, match_cnt=0. rst asserted mid-RUN -> all outputs return to reset values.
- With PAT_DET_TIMEOUT_EN, TO_BITS=64: 64 zero bits -> timeout=1, done=1. Without the macro, the same stimulus -> timeout stays 0 and busy=1.
